// File: rtl/ks_bist_pkg.sv
// rtl/ks_bist_pkg.sv - shared types, constants and directed vectors for the adder BIST
package ks_bist_pkg;

    localparam int          WIDTH        = 16;
    localparam int unsigned NUM_DIRECTED = 8;
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    typedef enum logic {
        PH_DIRECTED,
        PH_RANDOM
    } phase_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } vec_t;

    // Corner cases: zero, carry-in only, small sum, full carry chain, alternating bits, sign overflow.
    function automatic vec_t directed_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    return {16'h0000, 16'h0000, 1'b0};
            3'd1:    return {16'h0000, 16'h0000, 1'b1};
            3'd2:    return {16'h0003, 16'h0005, 1'b0};
            3'd3:    return {16'hFFFF, 16'hFFFF, 1'b0};
            3'd4:    return {16'hAAAA, 16'h5555, 1'b0};
            3'd5:    return {16'h0001, 16'h0001, 1'b0};
            3'd6:    return {16'h7FFF, 16'h0001, 1'b0};
            default: return {16'hFFFF, 16'h0000, 1'b1};
        endcase
    endfunction

endpackage

// File: rtl/ks_adder_bist_if.sv
// rtl/ks_adder_bist_if.sv - operand/result bus between the BIST engine and the adder under test
interface ks_adder_bist_if;
    import ks_bist_pkg::*;

    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_cin;
    logic [WIDTH-1:0] dut_s;
    logic             dut_cout;

    modport master (
        output dut_a, dut_b, dut_cin,
        input  dut_s, dut_cout
    );

    modport slave (
        input  dut_a, dut_b, dut_cin,
        output dut_s, dut_cout
    );

endinterface

// File: rtl/ks_bist_lfsr.sv
// rtl/ks_bist_lfsr.sv - 32-bit Galois LFSR; exposes the next state so a step and its use share one edge
module ks_bist_lfsr
    import ks_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] lfsr_nxt
);

    // An all-zero state would lock the LFSR, so a zero seed is remapped.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        lfsr_nxt = {1'b0, state_q[31:1]} ^ ({32{state_q[0]}} & LFSR_TAPS);
        state_d  = state_q;
        if (load) begin
            state_d = SEED_EFF;
        end else if (step) begin
            state_d = lfsr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/ks_adder_bist.sv
// rtl/ks_adder_bist.sv - BIST engine: applies directed then LFSR vectors to the adder and checks the sums
module ks_adder_bist
    import ks_bist_pkg::*;
#(
    parameter int unsigned NUM_RANDOM = 256,
    parameter int unsigned SETTLE     = 1,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] err_count,
    output logic [WIDTH-1:0] vec_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [WIDTH-1:0] fail_s,
    output logic             fail_cout,
    ks_adder_bist_if.master  adder
);

    localparam int unsigned TOTAL       = NUM_DIRECTED + NUM_RANDOM;
    localparam logic [3:0]  SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t           state_q,     state_d;
    phase_t           phase_q,     phase_d;
    logic [3:0]       wait_cnt_q,  wait_cnt_d;
    logic [WIDTH-1:0] err_q,       err_d;
    logic [WIDTH-1:0] vec_q,       vec_d;
    vec_t             cur_q,       cur_d;
    vec_t             fail_vec_q,  fail_vec_d;
    logic [WIDTH-1:0] fail_s_q,    fail_s_d;
    logic             fail_cout_q, fail_cout_d;

    logic             lfsr_load;
    logic             lfsr_step;
    logic [31:0]      lfsr_nxt;
    logic [WIDTH:0]   expected;
    logic             mismatch;
    logic [31:0]      next_idx;

    ks_bist_lfsr #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .step     (lfsr_step),
        .lfsr_nxt (lfsr_nxt)
    );

    assign expected = {1'b0, cur_q.a} + {1'b0, cur_q.b} + {{WIDTH{1'b0}}, cur_q.cin};
    assign mismatch = (expected != {adder.dut_cout, adder.dut_s});
    assign next_idx = 32'(vec_q) + 32'd1;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        vec_d       = vec_q;
        cur_d       = cur_q;
        fail_vec_d  = fail_vec_q;
        fail_s_d    = fail_s_q;
        fail_cout_d = fail_cout_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_APPLY;
                    phase_d     = PH_DIRECTED;
                    err_d       = '0;
                    vec_d       = '0;
                    fail_vec_d  = '0;
                    fail_s_d    = '0;
                    fail_cout_d = 1'b0;
                    cur_d       = directed_vec(3'd0);
                    lfsr_load   = 1'b1;
                end
            end
            S_APPLY: begin
                wait_cnt_d = 4'd0;
                state_d    = (SETTLE == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                vec_d = vec_q + 1'b1;
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    // err_q only grows within a run, so zero marks the first failure.
                    if (err_q == '0) begin
                        fail_vec_d  = cur_q;
                        fail_s_d    = adder.dut_s;
                        fail_cout_d = adder.dut_cout;
                    end
                end
                if (next_idx >= TOTAL) begin
                    state_d = S_DONE;
                end else if (next_idx < NUM_DIRECTED) begin
                    state_d = S_APPLY;
                    cur_d   = directed_vec(next_idx[2:0]);
                end else begin
                    state_d   = S_APPLY;
                    phase_d   = PH_RANDOM;
                    lfsr_step = 1'b1;
                    cur_d     = {lfsr_nxt[31:16], lfsr_nxt[15:0], lfsr_nxt[31] ^ lfsr_nxt[0]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_DIRECTED;
            wait_cnt_q  <= '0;
            err_q       <= '0;
            vec_q       <= '0;
            cur_q       <= '0;
            fail_vec_q  <= '0;
            fail_s_q    <= '0;
            fail_cout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            vec_q       <= vec_d;
            cur_q       <= cur_d;
            fail_vec_q  <= fail_vec_d;
            fail_s_q    <= fail_s_d;
            fail_cout_q <= fail_cout_d;
        end
    end

    assign busy          = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);
    assign pass          = done && (err_q == '0);
    assign err_count     = err_q;
    assign vec_count     = vec_q;
    assign fail_a        = fail_vec_q.a;
    assign fail_b        = fail_vec_q.b;
    assign fail_cin      = fail_vec_q.cin;
    assign fail_s        = fail_s_q;
    assign fail_cout     = fail_cout_q;
    assign adder.dut_a   = cur_q.a;
    assign adder.dut_b   = cur_q.b;
    assign adder.dut_cin = cur_q.cin;

endmodule

// File: tb/tb_ks_adder_bist.sv
// tb/tb_ks_adder_bist.sv - self-checking bench for ks_adder_bist with a behavioural adder and result model
module tb_ks_adder_bist;

    localparam int          NR4   = 4;
    localparam int          ST4   = 1;
    localparam int          NR0   = 0;
    localparam int          ST0   = 0;
    localparam logic [31:0] SEED4 = 32'hACE1_2468;
    localparam logic [31:0] TAPS  = 32'h8020_0003;

    typedef struct {
        int          errs;
        int          vecs;
        logic [15:0] fa;
        logic [15:0] fb;
        logic [15:0] fs;
        logic        fcin;
        logic        fcout;
        logic [32:0] last;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0;
    logic start0 = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fault_mode = 0;
    int   fault_bit = 0;

    logic        busy4, done4, pass4, fcin4, fcout4;
    logic [15:0] err4, vec4, fa4, fb4, fs4;
    logic        busy0, done0, pass0, fcin0, fcout0;
    logic [15:0] err0, vec0, fa0, fb0, fs0;
    logic [16:0] r4, r0;

    logic [32:0] dir_tab [8] = '{
        {16'h0000, 16'h0000, 1'b0}, {16'h0000, 16'h0000, 1'b1},
        {16'h0003, 16'h0005, 1'b0}, {16'hFFFF, 16'hFFFF, 1'b0},
        {16'hAAAA, 16'h5555, 1'b0}, {16'h0001, 16'h0001, 1'b0},
        {16'h7FFF, 16'h0001, 1'b0}, {16'hFFFF, 16'h0000, 1'b1}
    };

    always #5 clk = ~clk;

    ks_adder_bist_if bus4 ();
    ks_adder_bist_if bus0 ();

    // Adder under test, with optional planted faults: 1 = sum bit 0 stuck low,
    // 2 = carry-out stuck low, 3 = sum bit fault_bit inverted whenever A has that bit set.
    function automatic logic [16:0] fadd(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input int mode, input int fb);
        logic [16:0] r;
        r = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        case (mode)
            1: r[0] = 1'b0;
            2: r[16] = 1'b0;
            3: if (a[fb]) r[fb] = ~r[fb];
            default: ;
        endcase
        return r;
    endfunction

    assign r4 = fadd(bus4.dut_a, bus4.dut_b, bus4.dut_cin, fault_mode, fault_bit);
    assign bus4.dut_s    = r4[15:0];
    assign bus4.dut_cout = r4[16];
    assign r0 = fadd(bus0.dut_a, bus0.dut_b, bus0.dut_cin, fault_mode, fault_bit);
    assign bus0.dut_s    = r0[15:0];
    assign bus0.dut_cout = r0[16];

    ks_adder_bist #(.NUM_RANDOM(NR4), .SETTLE(ST4), .SEED(SEED4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .vec_count(vec4), .fail_a(fa4), .fail_b(fb4), .fail_cin(fcin4),
        .fail_s(fs4), .fail_cout(fcout4), .adder(bus4)
    );

    ks_adder_bist #(.NUM_RANDOM(NR0), .SETTLE(ST0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .vec_count(vec0), .fail_a(fa0), .fail_b(fb0), .fail_cin(fcin0),
        .fail_s(fs0), .fail_cout(fcout0), .adder(bus0)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        if (s[0]) return (s >> 1) ^ TAPS;
        return s >> 1;
    endfunction

    // Whole-run outcome from the vector list and integer arithmetic.
    function automatic res_t model(input int nrand, input logic [31:0] seed, input int mode, input int fb);
        res_t        m;
        logic [31:0] s;
        logic [32:0] v;
        logic [16:0] obs;
        int          sum;
        m.errs = 0; m.vecs = 0; m.fa = 0; m.fb = 0; m.fs = 0; m.fcin = 0; m.fcout = 0; m.last = 0;
        s = (seed == 0) ? 32'h1 : seed;
        for (int i = 0; i < 8 + nrand; i++) begin
            if (i < 8) begin
                v = dir_tab[i];
            end else begin
                s = lfsr_next(s);
                v = {s[31:16], s[15:0], s[31] ^ s[0]};
            end
            obs = fadd(v[32:17], v[16:1], v[0], mode, fb);
            sum = int'(v[32:17]) + int'(v[16:1]) + int'(v[0]);
            if (int'(obs) != sum) begin
                if (m.errs == 0) begin
                    m.fa = v[32:17]; m.fb = v[16:1]; m.fcin = v[0];
                    m.fs = obs[15:0]; m.fcout = obs[16];
                end
                if (m.errs < 65535) m.errs++;
            end
            m.vecs++;
            m.last = v;
        end
        return m;
    endfunction

    task automatic pulse4();
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
    endtask

    task automatic wait_done4(output int n);
        n = 0;
        while (!done4 && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_run4(input string tag, input int mode, input int fb);
        res_t m;
        m = model(NR4, SEED4, mode, fb);
        checks++;
        if (err4 !== 16'(m.errs)) begin errors++; $display("FAIL %s err_count: got %0d want %0d", tag, err4, m.errs); end
        checks++;
        if (vec4 !== 16'(m.vecs)) begin errors++; $display("FAIL %s vec_count: got %0d want %0d", tag, vec4, m.vecs); end
        checks++;
        if ({fa4, fb4, fcin4, fs4, fcout4} !== {m.fa, m.fb, m.fcin, m.fs, m.fcout}) begin
            errors++;
            $display("FAIL %s fail_vec: got a=%h b=%h cin=%b s=%h cout=%b want a=%h b=%h cin=%b s=%h cout=%b",
                     tag, fa4, fb4, fcin4, fs4, fcout4, m.fa, m.fb, m.fcin, m.fs, m.fcout);
        end
        checks++;
        if (pass4 !== (m.errs == 0)) begin errors++; $display("FAIL %s pass: got %b want %b", tag, pass4, m.errs == 0); end
        checks++;
        if ({bus4.dut_a, bus4.dut_b, bus4.dut_cin} !== m.last) begin
            errors++; $display("FAIL %s last_vec: got %h want %h", tag, {bus4.dut_a, bus4.dut_b, bus4.dut_cin}, m.last);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, pass4, err4, vec4, fa4, fb4, fcin4, fs4, fcout4, bus4.dut_a, bus4.dut_b, bus4.dut_cin} !== '0) begin
            errors++; $display("FAIL reset_dut4: outputs not all zero (busy=%b done=%b err=%h vec=%h a=%h)", busy4, done4, err4, vec4, bus4.dut_a);
        end
        checks++;
        if ({busy0, done0, pass0, err0, vec0, fa0, fb0, fcin0, fs0, fcout0, bus0.dut_a, bus0.dut_b, bus0.dut_cin} !== '0) begin
            errors++; $display("FAIL reset_dut0: outputs not all zero (busy=%b done=%b err=%h vec=%h a=%h)", busy0, done0, err0, vec0, bus0.dut_a);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy4, done4, busy0, done0} !== 4'b0) begin
            errors++; $display("FAIL idle_no_start: got busy/done=%b want 0000", {busy4, done4, busy0, done0});
        end
    endtask

    task automatic test_basic();
        int n;
        fault_mode = 0;
        pulse4();
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy4); end
        checks++;
        if ({bus4.dut_a, bus4.dut_b, bus4.dut_cin} !== dir_tab[0]) begin
            errors++; $display("FAIL first_vec: got %h want %h", {bus4.dut_a, bus4.dut_b, bus4.dut_cin}, dir_tab[0]);
        end
        wait_done4(n);
        checks++;
        if (n != (8 + NR4) * (ST4 + 2)) begin errors++; $display("FAIL run_latency: got %0d want %0d", n, (8 + NR4) * (ST4 + 2)); end
        check_run4("basic", 0, 0);
        checks++;
        if ({pass4, err4, vec4} !== {1'b1, 16'd0, 16'd12}) begin
            errors++; $display("FAIL basic_plan: got pass=%b err=%0d vec=%0d want 1/0/12", pass4, err4, vec4);
        end
    endtask

    task automatic test_fault_s0();
        int n;
        fault_mode = 1;
        pulse4();
        wait_done4(n);
        check_run4("s0", 1, 0);
        checks++;
        if ({fa4, fb4, fcin4, fs4, fcout4, pass4} !== {16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL s0_plan: got a=%h b=%h cin=%b s=%h cout=%b pass=%b", fa4, fb4, fcin4, fs4, fcout4, pass4);
        end
    endtask

    task automatic test_fault_cout();
        int n;
        fault_mode = 2;
        pulse4();
        wait_done4(n);
        check_run4("cout", 2, 0);
        checks++;
        if ({fa4, fb4, fs4, fcout4} !== {16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0} || err4 < 16'd2) begin
            errors++; $display("FAIL cout_plan: got a=%h b=%h s=%h cout=%b err=%0d", fa4, fb4, fs4, fcout4, err4);
        end
    endtask

    task automatic test_random_fault();
        int n;
        for (int k = 0; k < 3; k++) begin
            fault_mode = 3;
            fault_bit  = $urandom_range(0, 15);
            pulse4();
            wait_done4(n);
            check_run4($sformatf("rand_bit%0d", fault_bit), 3, fault_bit);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        fault_mode = 0;
        pulse4();
        n = 0;
        while (vec4 != 16'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (vec4 != 16'd5) begin errors++; $display("FAIL reach_vec5: got %0d want 5", vec4); end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy4, done4, pass4, err4, vec4, fa4, fb4, fcin4, fs4, fcout4, bus4.dut_a, bus4.dut_b, bus4.dut_cin} !== '0) begin
            errors++; $display("FAIL mid_reset: outputs not zero (busy=%b vec=%0d a=%h b=%h)", busy4, vec4, bus4.dut_a, bus4.dut_b);
        end
        @(negedge clk) rst = 1'b0;
        pulse4();
        wait_done4(n);
        checks++;
        if (n != (8 + NR4) * (ST4 + 2)) begin errors++; $display("FAIL rerun_latency: got %0d want %0d", n, (8 + NR4) * (ST4 + 2)); end
        check_run4("after_reset", 0, 0);
    endtask

    task automatic test_back_to_back();
        int n;
        fault_mode = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        n = 0;
        while (!done0 && n < 1000) begin
            @(negedge clk);
            n++;
            start0 = 1'b0;
            if (!done0 && n < 14) start0 = 1'($urandom_range(0, 1));
        end
        start0 = 1'b0;
        checks++;
        if (n != 8 * (ST0 + 2)) begin errors++; $display("FAIL nr0_latency: got %0d want %0d", n, 8 * (ST0 + 2)); end
        checks++;
        if ({pass0, busy0, err0, vec0} !== {1'b1, 1'b0, 16'd0, 16'd8}) begin
            errors++; $display("FAIL nr0_result: got pass=%b busy=%b err=%0d vec=%0d want 1/0/0/8", pass0, busy0, err0, vec0);
        end
        checks++;
        if ({bus0.dut_a, bus0.dut_b, bus0.dut_cin} !== dir_tab[7]) begin
            errors++; $display("FAIL nr0_last_vec: got %h want %h", {bus0.dut_a, bus0.dut_b, bus0.dut_cin}, dir_tab[7]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done0, vec0} !== {1'b1, 16'd8}) begin
            errors++; $display("FAIL nr0_done_held: got done=%b vec=%0d want 1/8", done0, vec0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_fault_s0();
        test_fault_cout();
        test_random_fault();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
